// File: rtl/mult_seq_shift_add.sv
// Multi-cycle shift-add multiplier with a signed/unsigned mode and
// valid/ready handshakes on both the operand and the result side.
module mult_seq_shift_add #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1,
    parameter bit SIGNED_EN      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [PW-1:0]    a_sh;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    part;
    logic [PW-1:0]    acc_next;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [CW-1:0]    cnt;
    logic             neg;
    logic             sgn;

    assign sgn   = SIGNED_EN && signed_mode;
    // Two's complement negate of the most negative value yields 2^(WIDTH-1) unsigned
    assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;

    // a_sh already carries the counter*BITS_PER_CYCLE weighting
    assign part     = a_sh * PW'(b_sh[BITS_PER_CYCLE-1:0]);
    assign acc_next = acc + part;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            product   <= '0;
            acc       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= PW'(a_mag);
                        b_sh  <= b_mag;
                        neg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc  <= acc_next;
                    a_sh <= a_sh << BITS_PER_CYCLE;
                    b_sh <= b_sh >> BITS_PER_CYCLE;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        product   <= neg ? -acc_next : acc_next;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_shift_add.sv
// Bench for mult_seq_shift_add: directed vectors, handshake corner cases,
// two alternate parameter sets and a randomised run against a reference model.
module tb_mult_seq_shift_add;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [15:0] product;

    logic        v2, r2, sm2, ov2, or2, bz2;
    logic [7:0]  a2, b2;
    logic [15:0] p2;

    logic        v3, r3, sm3, ov3, or3, bz3;
    logic [15:0] a3, b3;
    logic [31:0] p3;

    int checks = 0;
    int errors = 0;

    mult_seq_shift_add #(.WIDTH(8), .BITS_PER_CYCLE(1), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .busy(busy)
    );

    mult_seq_shift_add #(.WIDTH(8), .BITS_PER_CYCLE(2), .SIGNED_EN(1'b1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2),
        .a(a2), .b(b2), .signed_mode(sm2), .out_valid(ov2),
        .out_ready(or2), .product(p2), .busy(bz2)
    );

    mult_seq_shift_add #(.WIDTH(16), .BITS_PER_CYCLE(4), .SIGNED_EN(1'b1)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3),
        .a(a3), .b(b3), .signed_mode(sm3), .out_valid(ov3),
        .out_ready(or3), .product(p3), .busy(bz3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        bit          sm;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input bit sm);
        int p;
        if (sm) p = int'($signed(x)) * int'($signed(y));
        else    p = int'(x) * int'(y);
        return p[15:0];
    endfunction

    // Presents one operand pair while idle, returns product and cycles to out_valid
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input bit sm,
                          output logic [15:0] p, output int lat);
        a = x;
        b = y;
        signed_mode = sm;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'hxx;
        b = 8'hxx;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        p = product;
    endtask

    logic [15:0] exp_q[$];
    int          sent, got;
    logic [15:0] p;
    int          lat;

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;
        v2 = 1'b0; a2 = '0; b2 = '0; sm2 = 1'b0; or2 = 1'b1;
        v3 = 1'b0; a3 = '0; b3 = '0; sm3 = 1'b0; or3 = 1'b1;

        vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[2] = '{8'hFF, 8'h7F, 1'b1, 16'hFF81};
        vecs[3] = '{8'h00, 8'h80, 1'b1, 16'h0000};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 16'h4000};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[6] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[7] = '{8'h80, 8'h01, 1'b1, 16'hFF80};
        vecs[8] = '{8'h00, 8'h00, 1'b0, 16'h0000};
        vecs[9] = '{8'h0C, 8'h0D, 1'b0, 16'h009C};

        #2 rst = 1'b1;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        #18 rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].x, vecs[i].y, vecs[i].sm, p, lat);
            check($sformatf("vec%0d_product", i), 32'(p), 32'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            @(posedge clk); #1;
            check($sformatf("vec%0d_released", i), 32'({out_valid, in_ready}), 32'b01);
        end

        // Backpressure: result held in DONE, new operands refused
        out_ready = 1'b0;
        run_op(8'd3, 8'd5, 1'b0, p, lat);
        check("bp_first", 32'(p), 32'd15);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                a = 8'd9; b = 8'd9; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("bp_hold", 32'({out_valid, in_ready, busy, product}),
                  32'({1'b1, 1'b0, 1'b1, 16'd15}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 32'({out_valid, in_ready}), 32'b01);
        repeat (12) @(posedge clk);
        #1;
        check("bp_no_dup", 32'({out_valid, busy}), 32'b00);

        // Asynchronous reset in the middle of a calculation
        run_op_start: begin
            a = 8'd100; b = 8'd100; signed_mode = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (3) @(posedge clk);
            #2 rst = 1'b1;
            #1;
            check("mid_rst", 32'({out_valid, in_ready, busy, product}),
                  32'({1'b0, 1'b1, 1'b0, 16'd0}));
            #3 rst = 1'b0;
            @(posedge clk); #1;
        end
        run_op(8'd12, 8'd13, 1'b0, p, lat);
        check("post_rst_product", 32'(p), 32'd156);
        @(posedge clk); #1;

        // BITS_PER_CYCLE=2
        a2 = 8'd200; b2 = 8'd3; sm2 = 1'b0; v2 = 1'b1;
        @(posedge clk); #1;
        v2 = 1'b0;
        lat = 0;
        while (!ov2 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bpc2_product", 32'(p2), 32'd600);
        check("bpc2_latency", 32'(lat), 32'd4);
        @(posedge clk); #1;

        // WIDTH=16, BITS_PER_CYCLE=4
        for (int k = 0; k < 2; k++) begin
            a3 = (k == 0) ? 16'h8000 : 16'hFFFF;
            b3 = (k == 0) ? 16'h7FFF : 16'hFFFF;
            sm3 = (k == 0);
            v3 = 1'b1;
            @(posedge clk); #1;
            v3 = 1'b0;
            lat = 0;
            while (!ov3 && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            check("w16_product", p3, (k == 0) ? 32'hC0008000 : 32'hFFFE0001);
            check("w16_latency", 32'(lat), 32'd4);
            @(posedge clk); #1;
        end

        // Randomised traffic with independent producer and consumer stalls
        sent = 0;
        got = 0;
        fork
            begin : producer
                bit pending = 1'b0;
                int guard = 0;
                while (sent < 1000 && guard < 60000) begin
                    @(posedge clk); #1;
                    guard++;
                    if (!pending) begin
                        if ($urandom_range(0, 3) == 0) begin
                            in_valid = 1'b0;
                        end else begin
                            a = 8'($urandom);
                            b = 8'($urandom);
                            signed_mode = 1'($urandom);
                            in_valid = 1'b1;
                            pending = 1'b1;
                        end
                    end
                    if (pending && in_ready) begin
                        exp_q.push_back(model(a, b, signed_mode));
                        pending = 1'b0;
                        sent++;
                    end
                end
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            begin : consumer
                int guard = 0;
                while (got < 1000 && guard < 60000) begin
                    @(posedge clk); #1;
                    guard++;
                    out_ready = ($urandom_range(0, 1) == 1);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rand_extra", 32'(product), 32'hFFFFFFFF);
                        end else begin
                            check("rand_product", 32'(product), 32'(exp_q.pop_front()));
                        end
                        got++;
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        check("rand_sent", 32'(sent), 32'd1000);
        check("rand_got", 32'(got), 32'd1000);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("rand_quiet", 32'({out_valid, busy, in_ready}), 32'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
